mc_ctrl_fsm: RTL and testbench



---
 rtl/mc_ctrl_fsm.sv | 257 +++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control state machine for the multicycle MIPS datapath.
// It decodes IR[31:26] into datapath strobes, handles memory ready/wait,
// supports lw/sw/R-type/beq/bne/j/addi, and halts on illegal opcodes or
// memory timeouts.
// Optional feature macro: MC_PERF_CNT_EN builds the retired-instruction
// counter; without it instr_count is tied to zero.
module mc_ctrl_fsm #(
   parameter int OPCODE_W    = 6,
   parameter int MEM_TIMEOUT = 15,
   parameter int TMO_W       = 4,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                PCWriteCond,
   output logic                PCWrite,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemtoReg,
   output logic                IRWrite,
   output logic                RegDst,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ALUOp,
   output logic [1:0]          PCSource,
   output logic                branch_ne,
   output logic [3:0]          state,
   output logic                retire,
   output logic [CNT_W-1:0]    instr_count,
   output logic                illegal_op,
   output logic                mem_timeout
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_ADDI_EX = 4'd10,
      S_ADDI_WB = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
   localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
   localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
   localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
   localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
   localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
   localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);

   state_t           state_q;
   state_t           state_d;
   logic [TMO_W-1:0] wait_cnt;
   logic             mem_wait_state;
   logic             timeout_hit;
   logic             set_illegal;
   logic             set_timeout;

   assign state = state_q;

   // States in which the wait counter runs while memory is not ready.
   assign mem_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                           (state_q == S_MEMWR);

   // Timeout fires only while still waiting; a ready in the same cycle wins.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                        (wait_cnt == TMO_W'(MEM_TIMEOUT));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_d     = state_q;
      set_illegal = 1'b0;
      set_timeout = 1'b0;
      PCWriteCond = 1'b0;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      branch_ne   = 1'b0;
      retire      = 1'b0;

      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeout_hit) begin
               state_d     = S_HALT;
               set_timeout = 1'b1;
            end
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (opcode)
               OP_RTYPE:      state_d = S_EXEC;
               OP_LW, OP_SW:  state_d = S_MEMADR;
               OP_BEQ, OP_BNE: state_d = S_BRANCH;
               OP_J:          state_d = S_JUMP;
               OP_ADDI:       state_d = S_ADDI_EX;
               default: begin
                  state_d     = S_HALT;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (mem_ready) begin
               state_d = S_MEMWB;
            end else if (timeout_hit) begin
               state_d     = S_HALT;
               set_timeout = 1'b1;
            end
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (timeout_hit) begin
               state_d     = S_HALT;
               set_timeout = 1'b1;
            end
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_RWB;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            branch_ne   = opcode[0];
            retire      = 1'b1;
            state_d     = S_FETCH;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_ADDI_EX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            RegWrite = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase

      // Architectural write strobes stay quiet for the whole reset window,
      // even though the reset state's decode would raise some of them.
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         MemWrite    = 1'b0;
      end
   end

   // Memory wait counter: cleared on any state change, counts stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (state_d != state_q) begin
         wait_cnt <= '0;
      end else if (mem_wait_state && !mem_ready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // Sticky halt-cause flags, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_op  <= 1'b0;
         mem_timeout <= 1'b0;
      end else begin
         if (set_illegal) illegal_op  <= 1'b1;
         if (set_timeout) mem_timeout <= 1'b1;
      end
   end

`ifdef MC_PERF_CNT_EN
   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instr_count <= '0;
      else if (retire) instr_count <= instr_count + CNT_W'(1);
   end
`else
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed self-checking bench for mc_ctrl_fsm.
module tb_mc_ctrl_fsm;

   logic        clk;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        mem_ready;
   logic        PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
   logic        IRWrite, RegDst, RegWrite, ALUSrcA;
   logic [1:0]  ALUSrcB, ALUOp, PCSource;
   logic        branch_ne;
   logic [3:0]  state;
   logic        retire;
   logic [31:0] instr_count;
   logic        illegal_op;
   logic        mem_timeout;

   int n_checks = 0;
   int n_pass   = 0;
   int exp_retired = 0;

   mc_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWriteCond(PCWriteCond), .PCWrite(PCWrite), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .branch_ne(branch_ne), .state(state),
      .retire(retire), .instr_count(instr_count), .illegal_op(illegal_op),
      .mem_timeout(mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control vector: PCWriteCond PCWrite IorD MemRead MemWrite MemtoReg
   // IRWrite RegDst RegWrite ALUSrcA | ALUSrcB | ALUOp | PCSource | branch_ne
   logic [16:0] ctrl;
   assign ctrl = {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg,
                  IRWrite, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                  PCSource, branch_ne};

   localparam logic [16:0] C_FETCH_R = 17'b0_1_0_1_0_0_1_0_0_0_01_00_00_0;
   localparam logic [16:0] C_FETCH_W = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] C_DECODE  = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] C_MEMADR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] C_MEMRD   = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_MEMWB   = 17'b0_0_0_0_0_1_0_0_1_0_00_00_00_0;
   localparam logic [16:0] C_MEMWR   = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] C_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] C_RWB     = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] C_BNE     = 17'b1_0_0_0_0_0_0_0_0_1_00_01_01_1;
   localparam logic [16:0] C_BEQ     = 17'b1_0_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] C_JUMP    = 17'b0_1_0_0_0_0_0_0_0_0_00_00_10_0;
   localparam logic [16:0] C_ADDI_WB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
   localparam logic [16:0] C_HALT    = 17'b0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] exp_count();
`ifdef MC_PERF_CNT_EN
      return 32'(exp_retired);
`else
      return 32'd0;
`endif
   endfunction

   // Check state, control vector and retire for the current cycle, then advance.
   task automatic expect_cycle(input string tag, input logic [3:0] st,
                               input logic [16:0] c, input logic ret);
      #1;
      check({tag, " state"}, 32'(state), 32'(st));
      check({tag, " ctrl"}, 32'(ctrl), 32'(c));
      check({tag, " retire"}, 32'(retire), 32'(ret));
      if (ret) exp_retired++;
      tick();
   endtask

   // Asynchronous reset pulse applied away from the clock edge.
   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      check({tag, " rst state"}, 32'(state), 32'd0);
      check({tag, " rst illegal"}, 32'(illegal_op), 32'd0);
      check({tag, " rst timeout"}, 32'(mem_timeout), 32'd0);
      check({tag, " rst count"}, instr_count, 32'd0);
      tick();
      rst_n = 1'b1;
      exp_retired = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b1;
      opcode = 6'b000000;
      tick();
      tick();
      #1;
      check("reset state", 32'(state), 32'd0);
      check("reset ctrl forced", 32'(ctrl), 32'(C_FETCH_W));
      check("reset illegal", 32'(illegal_op), 32'd0);
      check("reset timeout", 32'(mem_timeout), 32'd0);
      check("reset count", instr_count, 32'd0);
      rst_n = 1'b1;

      // R-type, zero wait states: 0,1,6,7
      expect_cycle("rt F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("rt D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("rt E", 4'd6, C_EXEC, 1'b0);
      expect_cycle("rt W", 4'd7, C_RWB, 1'b1);

      // lw with three wait cycles in MEMRD
      opcode = 6'b100011;
      expect_cycle("lw F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("lw D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("lw A", 4'd2, C_MEMADR, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) expect_cycle("lw R wait", 4'd3, C_MEMRD, 1'b0);
      mem_ready = 1'b1;
      expect_cycle("lw R rdy", 4'd3, C_MEMRD, 1'b0);
      expect_cycle("lw WB", 4'd4, C_MEMWB, 1'b1);
      #1 check("lw count", instr_count, exp_count());

      // sw, zero wait states: 0,1,2,5
      opcode = 6'b101011;
      expect_cycle("sw F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("sw D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("sw A", 4'd2, C_MEMADR, 1'b0);
      expect_cycle("sw W", 4'd5, C_MEMWR, 1'b1);

      // bne then beq
      opcode = 6'b000101;
      expect_cycle("bne F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("bne D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("bne B", 4'd8, C_BNE, 1'b1);
      opcode = 6'b000100;
      expect_cycle("beq F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("beq D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("beq B", 4'd8, C_BEQ, 1'b1);

      // j
      opcode = 6'b000010;
      expect_cycle("j F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("j D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("j J", 4'd9, C_JUMP, 1'b1);

      // addi
      opcode = 6'b001000;
      expect_cycle("addi F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("addi D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("addi X", 4'd10, C_MEMADR, 1'b0);
      expect_cycle("addi W", 4'd11, C_ADDI_WB, 1'b1);
      #1 check("seven retired count", instr_count, exp_count());

      // Illegal opcode halts for good
      opcode = 6'b111111;
      expect_cycle("ill F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("ill D", 4'd1, C_DECODE, 1'b0);
      for (int i = 0; i < 20; i++) expect_cycle("ill H", 4'd12, C_HALT, 1'b0);
      #1;
      check("ill flag", 32'(illegal_op), 32'd1);
      check("ill no timeout", 32'(mem_timeout), 32'd0);
      do_reset("ill");
      opcode = 6'b000000;
      expect_cycle("ill rec F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("ill rec D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("ill rec E", 4'd6, C_EXEC, 1'b0);
      expect_cycle("ill rec W", 4'd7, C_RWB, 1'b1);

      // FETCH timeout: 16 stalled cycles then HALT
      do_reset("tmo");
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) expect_cycle("tmo F", 4'd0, C_FETCH_W, 1'b0);
      #1;
      check("tmo state", 32'(state), 32'd12);
      check("tmo flag", 32'(mem_timeout), 32'd1);
      check("tmo no illegal", 32'(illegal_op), 32'd0);
      mem_ready = 1'b1;
      expect_cycle("tmo H1", 4'd12, C_HALT, 1'b0);
      expect_cycle("tmo H2", 4'd12, C_HALT, 1'b0);

      // Ready on the 16th cycle wins over the timeout
      do_reset("tmo16");
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) expect_cycle("t16 F", 4'd0, C_FETCH_W, 1'b0);
      mem_ready = 1'b1;
      expect_cycle("t16 F rdy", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("t16 D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("t16 E", 4'd6, C_EXEC, 1'b0);
      expect_cycle("t16 W", 4'd7, C_RWB, 1'b1);
      #1 check("t16 no timeout", 32'(mem_timeout), 32'd0);

      // MEMRD timeout after earlier FETCH stalls (counter restarts per state)
      do_reset("rdtmo");
      opcode = 6'b100011;
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) expect_cycle("rdt F", 4'd0, C_FETCH_W, 1'b0);
      mem_ready = 1'b1;
      expect_cycle("rdt F rdy", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("rdt D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("rdt A", 4'd2, C_MEMADR, 1'b0);
      mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) expect_cycle("rdt R", 4'd3, C_MEMRD, 1'b0);
      #1;
      check("rdt state", 32'(state), 32'd12);
      check("rdt flag", 32'(mem_timeout), 32'd1);

      // Reset during MEMWR drops MemWrite immediately
      do_reset("wr");
      opcode = 6'b101011;
      mem_ready = 1'b1;
      expect_cycle("wr F", 4'd0, C_FETCH_R, 1'b0);
      expect_cycle("wr D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("wr A", 4'd2, C_MEMADR, 1'b0);
      mem_ready = 1'b0;
      #1;
      check("wr MemWrite hi", 32'(MemWrite), 32'd1);
      check("wr state", 32'(state), 32'd5);
      rst_n = 1'b0;
      #1;
      check("wr MemWrite async", 32'(MemWrite), 32'd0);
      check("wr state async", 32'(state), 32'd0);
      check("wr count async", instr_count, 32'd0);
      tick();
      rst_n = 1'b1;
      exp_retired = 0;
      mem_ready = 1'b1;
      opcode = 6'b000000;
      expect_cycle("wr rec F", 4'd0, C_FETCH_R, 1'b0);
      #1 check("wr rec count", instr_count, 32'd0);
      expect_cycle("wr rec D", 4'd1, C_DECODE, 1'b0);
      expect_cycle("wr rec E", 4'd6, C_EXEC, 1'b0);
      expect_cycle("wr rec W", 4'd7, C_RWB, 1'b1);
      #1 check("wr rec count end", instr_count, exp_count());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
